// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter: shares one SDRAM controller port between SLOTS requesters.
// Latency: grant is registered one edge after slot_req; slot_ack follows sdram_ack combinationally; slot_dok is one cycle after sdram_rdy.
// Backpressure: holds one transaction at a time until sdram_rdy or the watchdog fires; other slots wait.
module jtframe_sdram_arb #(
  parameter int SLOTS = 4,
  parameter int TOUT  = 255,
  parameter int SW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SLOTS-1:0]      slot_req,
  input  logic [SLOTS-1:0]      slot_rnw,
  input  logic [22*SLOTS-1:0]   slot_addr,
  input  logic [16*SLOTS-1:0]   slot_wrdata,
  output logic [SLOTS-1:0]      slot_ack,
  output logic [SLOTS-1:0]      slot_dok,
  output logic [31:0]           data_read,
  output logic                  sdram_req,
  output logic                  sdram_rnw,
  output logic [21:0]           sdram_addr,
  output logic [15:0]           sdram_din,
  input  logic                  sdram_ack,
  input  logic                  sdram_rdy,
  input  logic [31:0]           sdram_dout,
  output logic                  timeout
);

  localparam int CW = $clog2(TOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     ptr, sel, pick, sel_inc;
  logic [CW-1:0]     wdog;
  logic              found, start, done, abort;
  logic [2*SLOTS-1:0] req_dbl;
  logic [SLOTS-1:0]  req_rot, sel_hot;
  logic              pick_rnw;
  logic [21:0]       pick_addr;
  logic [15:0]       pick_din;

  // Rotate the request vector so bit 0 corresponds to the slot at ptr
  assign req_dbl   = {slot_req, slot_req};
  assign req_rot   = SLOTS'(req_dbl >> ptr);
  assign sdram_req = (state == REQ);
  assign sel_inc   = (sel == SW'(SLOTS - 1)) ? '0 : sel + 1'b1;

  // Circular priority search from ptr, then mux out the winner's request fields
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_rnw  = 1'b0;
    pick_addr = '0;
    pick_din  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pick  = SW'((int'(ptr) + k) % SLOTS);
      end
    end
    for (int k = 0; k < SLOTS; k++) begin
      if (SW'(k) == pick) begin
        pick_rnw  = slot_rnw[k];
        pick_addr = slot_addr[22*k +: 22];
        pick_din  = slot_wrdata[16*k +: 16];
      end
    end
  end

  // Decode the owner index into ack (combinational on sdram_ack) and a one-hot for dok
  always_comb begin
    slot_ack = '0;
    sel_hot  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      sel_hot[k]  = (sel == SW'(k));
      slot_ack[k] = (state == REQ) && sdram_ack && (sel == SW'(k));
    end
  end

  // Next-state logic; ack together with rdy counts as an immediate completion
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          if (sdram_rdy) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdram_rdy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wdog == CW'(TOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latched request, watchdog, completion strobes and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel        <= '0;
      ptr        <= '0;
      wdog       <= '0;
      sdram_rnw  <= 1'b0;
      sdram_addr <= '0;
      sdram_din  <= '0;
      data_read  <= '0;
      slot_dok   <= '0;
      timeout    <= 1'b0;
    end else begin
      if (start) begin
        sel        <= pick;
        sdram_rnw  <= pick_rnw;
        sdram_addr <= pick_addr;
        sdram_din  <= pick_din;
      end
      // Cleared while waiting for ack so it starts from zero on entry to WAIT
      if (state == REQ)       wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 1'b1;
      if (done && sdram_rnw) data_read <= sdram_dout;
      slot_dok <= done ? sel_hot : '0;
      timeout  <= abort;
      if (done || abort) ptr <= sel_inc;
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
module tb_jtframe_sdram_arb;
  localparam int SLOTS = 4;
  localparam int TOUT  = 15;
  localparam int SW    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [SLOTS-1:0]    slot_req, slot_rnw, slot_ack, slot_dok;
  logic [22*SLOTS-1:0] slot_addr;
  logic [16*SLOTS-1:0] slot_wrdata;
  logic [31:0]         data_read, sdram_dout;
  logic                sdram_req, sdram_rnw, sdram_ack, sdram_rdy, timeout;
  logic [21:0]         sdram_addr;
  logic [15:0]         sdram_din;

  int n_checks = 0;
  int n_fail   = 0;

  jtframe_sdram_arb #(.SLOTS(SLOTS), .TOUT(TOUT), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .slot_req(slot_req), .slot_rnw(slot_rnw), .slot_addr(slot_addr), .slot_wrdata(slot_wrdata),
    .slot_ack(slot_ack), .slot_dok(slot_dok), .data_read(data_read),
    .sdram_req(sdram_req), .sdram_rnw(sdram_rnw), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic rnw, input logic [21:0] a, input logic [15:0] d);
    slot_rnw[s]            = rnw;
    slot_addr[s*22 +: 22]  = a;
    slot_wrdata[s*16 +: 16] = d;
  endtask

  // ---------------- transaction-level reference model ----------------
  int          m_owner, m_wait, m_ptr, m_dok;
  bit          m_acked, m_tmo, m_rnw;
  logic [21:0] m_addr;
  logic [15:0] m_din;
  logic [31:0] m_data;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1; m_acked = 0; m_wait = 0; m_ptr = 0; m_dok = -1;
        m_tmo = 0; m_rnw = 0; m_addr = '0; m_din = '0; m_data = '0;
      end else begin
        int nd;
        bit nt, fin;
        nd = -1; nt = 0; fin = 0;
        if (m_owner < 0) begin
          for (int k = 0; k < SLOTS; k++) begin
            int i;
            i = (m_ptr + k) % SLOTS;
            if (m_owner < 0 && slot_req[i]) begin
              m_owner = i; m_acked = 0;
              m_rnw = slot_rnw[i]; m_addr = slot_addr[i*22 +: 22]; m_din = slot_wrdata[i*16 +: 16];
            end
          end
        end else if (!m_acked) begin
          if (sdram_ack) begin
            m_acked = 1; m_wait = 0; fin = sdram_rdy;
          end
        end else begin
          if (sdram_rdy) fin = 1;
          else begin
            m_wait++;
            if (m_wait == TOUT) begin
              nt = 1; m_ptr = (m_owner + 1) % SLOTS; m_owner = -1;
            end
          end
        end
        if (fin) begin
          if (m_rnw) m_data = sdram_dout;
          nd = m_owner; m_ptr = (m_owner + 1) % SLOTS; m_owner = -1;
        end
        m_dok = nd; m_tmo = nt;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  logic             e_req;
  logic [SLOTS-1:0] e_ack, e_dok;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_req = (m_owner >= 0) && !m_acked;
        e_ack = (e_req && sdram_ack) ? (SLOTS'(1) << m_owner) : '0;
        e_dok = (m_dok >= 0) ? (SLOTS'(1) << m_dok) : '0;
        check("m_sdram_req", sdram_req, e_req);
        check("m_slot_ack", slot_ack, e_ack);
        check("m_slot_dok", slot_dok, e_dok);
        check("m_timeout", timeout, m_tmo);
        check("m_data_read", data_read, m_data);
        if (e_req) begin
          check("m_sdram_rnw", sdram_rnw, m_rnw);
          check("m_sdram_addr", sdram_addr, m_addr);
          check("m_sdram_din", sdram_din, m_din);
        end
      end
    end
  end

  // Act as the controller for one granted transaction and check the owner's strobes
  task automatic serve(input int exp_slot, input int ack_dly, input int rdy_dly,
                       input logic [31:0] dout, input bit drop);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!sdram_req && n < 50);
    if (!sdram_req) check("serve_wait_req", sdram_req, 1'b1);
    repeat (ack_dly) tick();
    sdram_ack = 1'b1;
    @(negedge clk);
    check("serve_ack", slot_ack, SLOTS'(1) << exp_slot);
    tick();
    sdram_ack = 1'b0;
    if (drop) slot_req[exp_slot] = 1'b0;
    repeat (rdy_dly) tick();
    sdram_rdy  = 1'b1;
    sdram_dout = dout;
    tick();
    sdram_rdy = 1'b0;
    @(negedge clk);
    check("serve_dok", slot_dok, SLOTS'(1) << exp_slot);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  logic [SLOTS-1:0] acked;

  initial begin
    rst = 1'b1;
    slot_req = '0; slot_rnw = '1; slot_addr = '0; slot_wrdata = '0;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sdram_req", sdram_req, 1'b0);
    check("rst_slot_ack", slot_ack, 4'b0000);
    check("rst_slot_dok", slot_dok, 4'b0000);
    check("rst_timeout", timeout, 1'b0);
    check("rst_data_read", data_read, 32'h0);
    tick();
    rst = 1'b0;

    // Round robin over slots 0,1,3
    for (int s = 0; s < SLOTS; s++) set_slot(s, 1'b1, 22'(s * 4096 + 5), 16'(s));
    slot_req = 4'b1011;
    serve(0, 1, 1, 32'h00000011, 0);
    serve(1, 0, 2, 32'h00000022, 0);
    serve(3, 2, 0, 32'h00000033, 0);
    serve(0, 0, 3, 32'h00000044, 0);
    serve(1, 1, 1, 32'h00000055, 0);
    serve(3, 0, 0, 32'h00000066, 0);
    slot_req = '0;
    check("rr_data_read", data_read, 32'h00000066);

    // Single read from slot 2
    set_slot(2, 1'b1, 22'h01234, 16'h0000);
    slot_req = 4'b0100;
    tick();
    @(negedge clk);
    check("rd_sdram_req", sdram_req, 1'b1);
    check("rd_sdram_addr", sdram_addr, 22'h01234);
    check("rd_sdram_rnw", sdram_rnw, 1'b1);
    serve(2, 2, 4, 32'hDEADBEEF, 1);
    check("rd_data_read", data_read, 32'hDEADBEEF);

    // Write from slot 1 to the top address
    set_slot(1, 1'b0, 22'h3FFFFF, 16'hA55A);
    slot_req = 4'b0010;
    tick();
    @(negedge clk);
    check("wr_sdram_rnw", sdram_rnw, 1'b0);
    check("wr_sdram_din", sdram_din, 16'hA55A);
    check("wr_sdram_addr", sdram_addr, 22'h3FFFFF);
    serve(1, 1, 3, 32'h13572468, 1);
    check("wr_data_hold", data_read, 32'hDEADBEEF);

    // ack and rdy together for slot 0, slot 1 granted right behind it
    set_slot(0, 1'b1, 22'h00ABC, 16'h0);
    set_slot(1, 1'b1, 22'h00DEF, 16'h0);
    slot_req = 4'b0001;
    tick();
    @(negedge clk);
    check("ar_sdram_req", sdram_req, 1'b1);
    tick();
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_dout = 32'hCAFEF00D;
    slot_req = 4'b0010;
    @(negedge clk);
    check("ar_ack", slot_ack, 4'b0001);
    check("ar_no_dok_yet", slot_dok, 4'b0000);
    tick();
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    @(negedge clk);
    check("ar_dok", slot_dok, 4'b0001);
    check("ar_data", data_read, 32'hCAFEF00D);
    tick();
    @(negedge clk);
    check("ar_next_req", sdram_req, 1'b1);
    check("ar_next_addr", sdram_addr, 22'h00DEF);
    serve(1, 0, 1, 32'h0BADC0DE, 1);

    // Watchdog: slot 2 never completes, slot 3 served afterwards
    set_slot(2, 1'b1, 22'h02222, 16'h0);
    set_slot(3, 1'b1, 22'h03333, 16'h0);
    slot_req = 4'b1100;
    tick();
    @(negedge clk);
    check("wd_addr", sdram_addr, 22'h02222);
    tick();
    sdram_ack = 1'b1;
    @(negedge clk);
    check("wd_ack", slot_ack, 4'b0100);
    tick();
    sdram_ack = 1'b0;
    slot_req[2] = 1'b0;
    repeat (14) tick();
    @(negedge clk);
    check("wd_early", timeout, 1'b0);
    tick();
    @(negedge clk);
    check("wd_timeout", timeout, 1'b1);
    check("wd_no_dok", slot_dok, 4'b0000);
    serve(3, 1, 1, 32'h33333333, 1);

    // Reset asserted while waiting for rdy
    set_slot(0, 1'b1, 22'h00010, 16'h0);
    set_slot(1, 1'b1, 22'h00011, 16'h0);
    set_slot(3, 1'b1, 22'h00013, 16'h0);
    slot_req = 4'b0001;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    slot_req = 4'b1010;
    tick();
    rst = 1'b1;
    #1;
    check("rw_sdram_req", sdram_req, 1'b0);
    check("rw_slot_ack", slot_ack, 4'b0000);
    check("rw_slot_dok", slot_dok, 4'b0000);
    check("rw_timeout", timeout, 1'b0);
    tick();
    rst = 1'b0;
    serve(1, 0, 0, 32'h11111111, 1);
    serve(3, 0, 0, 32'h33330000, 1);
    slot_req = '0;

    // Randomized traffic against the model
    acked = '0;
    repeat (3000) begin
      tick();
      for (int s = 0; s < SLOTS; s++) begin
        if (acked[s]) slot_req[s] = 1'($urandom % 2);
        else if (!slot_req[s]) slot_req[s] = ($urandom % 4 == 0);
        set_slot(s, 1'($urandom % 2), 22'($urandom), 16'($urandom));
      end
      sdram_ack  = ($urandom % 3 == 0);
      sdram_rdy  = ($urandom % 3 == 0);
      sdram_dout = $urandom;
      @(negedge clk);
      acked = slot_ack;
    end
    tick();
    slot_req = '0; sdram_ack = 1'b0; sdram_rdy = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
